// File: rtl/frog_grid.sv
// Single-frog game tracker: holds the frog as a (col,row) coordinate, turns key
// presses into one-step moves, and handles hazards, lives, round wins and score.
module frog_grid #(
    parameter int COLS      = 8,
    parameter int ROWS      = 8,
    parameter int START_COL = COLS / 2,
    parameter int START_ROW = 0,
    parameter int LIVES     = 3,
    parameter int SCORE_W   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     L,
    input  logic                     R,
    input  logic                     F,
    input  logic                     B,
    input  logic                     hit,
    input  logic                     restart,
    output logic [ROWS*COLS-1:0]     lightOn,
    output logic [$clog2(COLS)-1:0]  frogCol,
    output logic [$clog2(ROWS)-1:0]  frogRow,
    output logic                     roundWin,
    output logic [3:0]               lives,
    output logic [SCORE_W-1:0]       score,
    output logic                     gameOver
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int NL = ROWS * COLS;
    localparam int IW = $clog2(NL);

    localparam logic [CW-1:0]      START_C   = CW'(START_COL);
    localparam logic [RW-1:0]      START_R   = RW'(START_ROW);
    localparam logic [CW-1:0]      LAST_COL  = CW'(COLS - 1);
    localparam logic [RW-1:0]      GOAL_ROW  = RW'(ROWS - 1);
    localparam logic [3:0]         LIVES_INI = 4'(LIVES);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        WIN  = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [CW-1:0]        col_reg, col_next;
    logic [RW-1:0]        row_reg, row_next;
    logic [3:0]           lives_reg, lives_next;
    logic [SCORE_W-1:0]   score_reg, score_next;
    logic [3:0]           prev_reg;

    logic [3:0] keys;
    logic [3:0] press;
    logic       move_valid;

    // Key bit order: [3]=L, [2]=R, [1]=F, [0]=B.
    assign keys       = {L, R, F, B};
    assign press      = keys & ~prev_reg;
    assign move_valid = $onehot(press);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= PLAY;
            col_reg   <= START_C;
            row_reg   <= START_R;
            lives_reg <= LIVES_INI;
            score_reg <= '0;
            // All-ones history: keys already held at reset release are not presses.
            prev_reg  <= 4'b1111;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
            lives_reg <= lives_next;
            score_reg <= score_next;
            prev_reg  <= keys;
        end
    end

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        lives_next = lives_reg;
        score_next = score_reg;
        case (state_reg)
            PLAY: begin
                if (hit) begin
                    if (lives_reg == 4'd1) begin
                        lives_next = 4'd0;
                        state_next = OVER;
                    end else begin
                        lives_next = lives_reg - 4'd1;
                        col_next   = START_C;
                        row_next   = START_R;
                    end
                end else if (move_valid) begin
                    // Wall-blocked presses fall through with the position unchanged.
                    if (press[3] && col_reg != '0)       col_next = col_reg - CW'(1);
                    if (press[2] && col_reg != LAST_COL) col_next = col_reg + CW'(1);
                    if (press[1])                        row_next = row_reg + RW'(1);
                    if (press[0] && row_reg != '0)       row_next = row_reg - RW'(1);
                    if (row_next == GOAL_ROW) begin
                        state_next = WIN;
                        score_next = (score_reg == SCORE_MAX) ? score_reg
                                                              : score_reg + SCORE_W'(1);
                    end
                end
            end
            WIN: begin
                col_next   = START_C;
                row_next   = START_R;
                state_next = PLAY;
            end
            OVER: begin
                if (restart) begin
                    state_next = PLAY;
                    col_next   = START_C;
                    row_next   = START_R;
                    lives_next = LIVES_INI;
                    score_next = '0;
                end
            end
            default: state_next = PLAY;
        endcase
    end

    logic [IW-1:0] frog_idx;
    assign frog_idx = IW'(row_reg) * IW'(COLS) + IW'(col_reg);

    generate
        for (genvar gi = 0; gi < NL; gi++) begin : g_light
            assign lightOn[gi] = (state_reg != OVER) && (frog_idx == IW'(gi));
        end
    endgenerate

    assign frogCol  = col_reg;
    assign frogRow  = row_reg;
    assign roundWin = (state_reg == WIN);
    assign gameOver = (state_reg == OVER);
    assign lives    = lives_reg;
    assign score    = score_reg;

endmodule

// File: tb/tb_frog_grid.sv
// Scoreboard bench for frog_grid on a 4x4 grid: each stimulus step queues the
// expected snapshot, which is popped and compared one cycle later.
module tb_frog_grid;

    logic        clk = 1'b0;
    logic        reset;
    logic        L, R, F, B, hit, restart;
    logic [15:0] lightOn;
    logic [1:0]  frogCol, frogRow;
    logic        roundWin, gameOver;
    logic [3:0]  lives;
    logic [1:0]  score;

    int tests = 0;
    int fails = 0;

    frog_grid #(
        .COLS(4), .ROWS(4), .START_COL(1), .START_ROW(0), .LIVES(2), .SCORE_W(2)
    ) dut (
        .clk(clk), .reset(reset), .L(L), .R(R), .F(F), .B(B),
        .hit(hit), .restart(restart), .lightOn(lightOn),
        .frogCol(frogCol), .frogRow(frogRow), .roundWin(roundWin),
        .lives(lives), .score(score), .gameOver(gameOver)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  col;
        logic [1:0]  row;
        logic [3:0]  lv;
        logic [1:0]  sc;
        logic        win;
        logic        over;
        logic [15:0] light;
    } snap_t;

    typedef struct packed {
        logic [3:0] keys;   // {L,R,F,B}
        logic       hit;
        logic       rs;
        snap_t      exp;
    } stim_t;

    snap_t exp_q[$];

    function automatic snap_t e(int c, int r, int lv, int sc, bit w, bit o);
        snap_t s;
        s.col   = 2'(c);
        s.row   = 2'(r);
        s.lv    = 4'(lv);
        s.sc    = 2'(sc);
        s.win   = w;
        s.over  = o;
        s.light = o ? 16'h0000 : (16'h0001 << (r * 4 + c));
        return s;
    endfunction

    function automatic stim_t st(logic [3:0] k, logic h, logic rs, snap_t x);
        stim_t s;
        s.keys = k;
        s.hit  = h;
        s.rs   = rs;
        s.exp  = x;
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.col   = frogCol;
        s.row   = frogRow;
        s.lv    = lives;
        s.sc    = score;
        s.win   = roundWin;
        s.over  = gameOver;
        s.light = lightOn;
        return s;
    endfunction

    task automatic drive(stim_t s);
        {L, R, F, B} = s.keys;
        hit          = s.hit;
        restart      = s.rs;
    endtask

    localparam logic [3:0] K0 = 4'b0000, KL = 4'b1000, KR = 4'b0100,
                           KF = 4'b0010, KB = 4'b0001;

    task automatic test_reset();
        stim_t t[$];
        snap_t got, want;
        reset = 1'b0;
        drive(st(K0, 1'b0, 1'b0, e(1, 0, 2, 0, 0, 0)));
        repeat (2) @(posedge clk);
        #1;
        got = dut_snap();
        want = e(1, 0, 2, 0, 0, 0);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL reset_state: got %h required %h", got, want);
        end
        $display("[TB] reset_state light=%h lives=%0d", lightOn, lives);
        R = 1'b1;
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        t.push_back(st(KR, 0, 0, e(1, 0, 2, 0, 0, 0)));
        t.push_back(st(KR, 0, 0, e(1, 0, 2, 0, 0, 0)));
        t.push_back(st(K0, 0, 0, e(1, 0, 2, 0, 0, 0)));
        t.push_back(st(KR, 0, 0, e(2, 0, 2, 0, 0, 0)));
        t.push_back(st(K0, 0, 0, e(2, 0, 2, 0, 0, 0)));
        t.push_back(st(KL, 0, 0, e(1, 0, 2, 0, 0, 0)));
        t.push_back(st(K0, 0, 0, e(1, 0, 2, 0, 0, 0)));
        foreach (t[i]) begin
            drive(t[i]);
            exp_q.push_back(t[i].exp);
            @(posedge clk);
            #1;
            got = dut_snap();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL held_through_reset step %0d: got %h required %h", i, got, want);
            end
            $display("[TB] held_through_reset step %0d col=%0d row=%0d", i, frogCol, frogRow);
        end
    endtask

    task automatic test_press_once();
        stim_t t[$];
        snap_t got, want;
        repeat (5) t.push_back(st(KR, 0, 0, e(2, 0, 2, 0, 0, 0)));
        t.push_back(st(K0, 0, 0, e(2, 0, 2, 0, 0, 0)));
        t.push_back(st(KL | KF, 0, 0, e(2, 0, 2, 0, 0, 0)));
        t.push_back(st(K0, 0, 0, e(2, 0, 2, 0, 0, 0)));
        t.push_back(st(KL, 0, 0, e(1, 0, 2, 0, 0, 0)));
        t.push_back(st(K0, 0, 0, e(1, 0, 2, 0, 0, 0)));
        foreach (t[i]) begin
            drive(t[i]);
            exp_q.push_back(t[i].exp);
            @(posedge clk);
            #1;
            got = dut_snap();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL press_once step %0d: got %h required %h", i, got, want);
            end
            $display("[TB] press_once step %0d col=%0d row=%0d light=%h", i, frogCol, frogRow, lightOn);
        end
    endtask

    task automatic test_walls();
        stim_t t[$];
        snap_t got, want;
        int cols[$] = '{0, 0, 0, 1, 2, 3, 3, 2, 1};
        logic [3:0] ks[$] = '{KL, KL, KB, KR, KR, KR, KR, KL, KL};
        foreach (ks[i]) begin
            t.push_back(st(ks[i], 0, 0, e(cols[i], 0, 2, 0, 0, 0)));
            t.push_back(st(K0, 0, 0, e(cols[i], 0, 2, 0, 0, 0)));
        end
        foreach (t[i]) begin
            drive(t[i]);
            exp_q.push_back(t[i].exp);
            @(posedge clk);
            #1;
            got = dut_snap();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL walls step %0d: got %h required %h", i, got, want);
            end
            $display("[TB] walls step %0d col=%0d row=%0d", i, frogCol, frogRow);
        end
    endtask

    task automatic test_win();
        stim_t t[$];
        snap_t got, want;
        t.push_back(st(KF, 0, 0, e(1, 1, 2, 0, 0, 0)));
        t.push_back(st(K0, 0, 0, e(1, 1, 2, 0, 0, 0)));
        t.push_back(st(KF, 0, 0, e(1, 2, 2, 0, 0, 0)));
        t.push_back(st(K0, 0, 0, e(1, 2, 2, 0, 0, 0)));
        t.push_back(st(KF, 0, 0, e(1, 3, 2, 1, 1, 0)));
        // Press R and assert hit during the one WIN cycle: both must be ignored.
        t.push_back(st(KR, 1, 0, e(1, 0, 2, 1, 0, 0)));
        t.push_back(st(K0, 0, 0, e(1, 0, 2, 1, 0, 0)));
        foreach (t[i]) begin
            drive(t[i]);
            exp_q.push_back(t[i].exp);
            @(posedge clk);
            #1;
            got = dut_snap();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL win step %0d: got %h required %h", i, got, want);
            end
            $display("[TB] win step %0d row=%0d roundWin=%0b score=%0d", i, frogRow, roundWin, score);
        end
    endtask

    task automatic test_hit_over();
        stim_t t[$];
        snap_t got, want;
        t.push_back(st(KR, 0, 0, e(2, 0, 2, 1, 0, 0)));
        t.push_back(st(K0, 0, 0, e(2, 0, 2, 1, 0, 0)));
        t.push_back(st(KF, 0, 0, e(2, 1, 2, 1, 0, 0)));
        t.push_back(st(K0, 0, 0, e(2, 1, 2, 1, 0, 0)));
        t.push_back(st(KR, 1, 0, e(1, 0, 1, 1, 0, 0)));
        t.push_back(st(K0, 0, 0, e(1, 0, 1, 1, 0, 0)));
        t.push_back(st(K0, 1, 0, e(1, 0, 0, 1, 0, 1)));
        t.push_back(st(KF, 0, 0, e(1, 0, 0, 1, 0, 1)));
        t.push_back(st(K0, 0, 0, e(1, 0, 0, 1, 0, 1)));
        t.push_back(st(K0, 1, 0, e(1, 0, 0, 1, 0, 1)));
        t.push_back(st(K0, 0, 1, e(1, 0, 2, 0, 0, 0)));
        t.push_back(st(K0, 0, 0, e(1, 0, 2, 0, 0, 0)));
        foreach (t[i]) begin
            drive(t[i]);
            exp_q.push_back(t[i].exp);
            @(posedge clk);
            #1;
            got = dut_snap();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL hit_over step %0d: got %h required %h", i, got, want);
            end
            $display("[TB] hit_over step %0d lives=%0d gameOver=%0b light=%h", i, lives, gameOver, lightOn);
        end
    endtask

    task automatic test_saturation_async_reset();
        stim_t t[$];
        snap_t got, want;
        for (int k = 1; k <= 4; k++) begin
            int sp = (k - 1 > 3) ? 3 : k - 1;
            int sn = (k > 3) ? 3 : k;
            t.push_back(st(KF, 0, 0, e(1, 1, 2, sp, 0, 0)));
            t.push_back(st(K0, 0, 0, e(1, 1, 2, sp, 0, 0)));
            t.push_back(st(KF, 0, 0, e(1, 2, 2, sp, 0, 0)));
            t.push_back(st(K0, 0, 0, e(1, 2, 2, sp, 0, 0)));
            t.push_back(st(KF, 0, 0, e(1, 3, 2, sn, 1, 0)));
            t.push_back(st(K0, 0, 0, e(1, 0, 2, sn, 0, 0)));
        end
        t.push_back(st(KR, 0, 0, e(2, 0, 2, 3, 0, 0)));
        foreach (t[i]) begin
            drive(t[i]);
            exp_q.push_back(t[i].exp);
            @(posedge clk);
            #1;
            got = dut_snap();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL saturation step %0d: got %h required %h", i, got, want);
            end
            $display("[TB] saturation step %0d row=%0d score=%0d", i, frogRow, score);
        end
        // Assert reset between edges; outputs must clear with no clock edge.
        #1 reset = 1'b0;
        exp_q.push_back(e(1, 0, 2, 0, 0, 0));
        #1;
        got = dut_snap();
        want = exp_q.pop_front();
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL async_reset: got %h required %h", got, want);
        end
        $display("[TB] async_reset col=%0d score=%0d", frogCol, score);
        drive(st(K0, 0, 0, e(1, 0, 2, 0, 0, 0)));
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        L = 1'b0; R = 1'b0; F = 1'b0; B = 1'b0;
        hit     = 1'b0;
        restart = 1'b0;
        test_reset();
        test_press_once();
        test_walls();
        test_win();
        test_hit_over();
        test_saturation_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frog_grid.md
Name: frog_grid

Overview:
- Parametrised successor to the per-light frog cell. Tracks one frog on a COLS x ROWS grid as a coordinate register instead of an array of neighbour-coupled cells.
- Adds:
  - press edge-detection (one move per press)
  - wall clamping
  - collision/lives handling
  - round-win pulse with auto-return to start
  - saturating score
- Sits between the debounced/synchronised KEY inputs and the LED-matrix driver.

Parameters:
- COLS, 8, grid columns (>=2)
- ROWS, 8, grid rows (>=2); row 0 is the start/bottom row, row ROWS-1 is the goal row
- START_COL, COLS/2, start column (< COLS)
- START_ROW, 0, start row (< ROWS-1)
- LIVES, 3, lives at reset/restart (1..15)
- SCORE_W, 4, score counter width

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserting low forces reset state immediately
- L  in  1  left key level, already synchronised
- R  in  1  right key level, already synchronised
- F  in  1  forward key level (row+1), already synchronised
- B  in  1  backward key level (row-1), already synchronised
- hit  in  1  collision with hazard at current frog position, level sampled each cycle
- restart  in  1  leave game-over; ignored in other states
- lightOn  out  ROWS*COLS  one-hot frog light, bit index row*COLS+col
- frogCol  out  $clog2(COLS)  current column
- frogRow  out  $clog2(ROWS)  current row
- roundWin  out  1  high for exactly one cycle after reaching goal row
- lives  out  4  remaining lives
- score  out  SCORE_W  rounds won, saturating
- gameOver  out  1  high while in OVER

Behaviour:
- Reset values (reset low, async):
  - state=PLAY; frog at (START_COL, START_ROW); lives=LIVES; score=0; roundWin=0; gameOver=0
  - key-history register = 4'b1111, so keys held through reset do not move the frog
- Press detection: press[k] = key[k] & ~prev[k]; prev <= {L,R,F,B} every cycle in every state.
- Valid move: exactly one press bit set. Zero or >=2 presses in the same cycle produce no move.
- Walls:
  - L at col 0, R at col COLS-1, B at row 0: no move, no wrap.
  - F is always legal below the goal row.
  - A press rejected at a wall is consumed; it does not retry.
- States: PLAY, WIN, OVER.
- PLAY, priority order per edge:
  1. hit=1:
     - if lives==1: lives<=0, state<=OVER, frog position held.
     - else: lives<=lives-1, frog<=start, state stays PLAY.
     - Any move that cycle is discarded.
  2. Valid move: position updates at that edge (1-cycle latency press->lightOn).
     - If the new row == ROWS-1: state<=WIN, score<=score+1, saturating at 2^SCORE_W-1.
- WIN (exactly 1 cycle):
  - roundWin=1; lightOn shows the frog in the goal row.
  - hit and presses are ignored.
  - Next edge: frog<=start, state<=PLAY.
- OVER:
  - gameOver=1; lightOn=0; frogCol/frogRow hold last position.
  - Presses and hit are ignored.
  - restart=1 at an edge: state<=PLAY, frog<=start, lives<=LIVES, score<=0.
- lightOn, gameOver and roundWin are decoded from registered state only; no combinational path from inputs to outputs.
- lightOn has exactly one bit set in PLAY/WIN, zero in OVER.
- Reset asserted mid-move or in WIN/OVER returns to the reset values immediately, without waiting for a clock edge.

Test Plan:
(COLS=4, ROWS=4, START_COL=1, START_ROW=0, LIVES=2, SCORE_W=2)
- Reset low, then high with all keys low -> frog (1,0), lightOn=16'h0002, lives=2, score=0. Hold R through reset release -> no move until R is released and pressed again.
- Press R held for 5 cycles -> frog moves once to (2,0), lightOn=16'h0004. Then L+F pressed in the same cycle -> no move.
- From (0,0) press L; from row 0 press B -> position unchanged both times. From (3,0) press R -> unchanged.
- Three separate F presses from (1,0) -> (1,1), (1,2), then (1,3) with roundWin=1 for one cycle and score=1. Next cycle frog (1,0), lightOn=16'h0002. F pressed during the WIN cycle -> ignored.
- hit in PLAY at (2,1) with a concurrent R press -> lives=1, frog (1,0), no move. A second hit -> lives=0, gameOver=1, lightOn=0. Presses are then ignored. restart pulse -> PLAY, lives=2, score=0, frog (1,0).
- Score saturation: four wins -> score stays 3. Assert reset low mid-game between edges -> outputs return to reset values without a clock edge.
